// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared width limits and output-register record for full_adder
package full_adder_pkg;
    localparam int FA_MAX_WIDTH = 64;
    localparam int FA_DEFAULT_WIDTH = 1;
    typedef struct packed {
        logic [FA_MAX_WIDTH-1:0] sum;
        logic                    cout;
        logic                    ovf;
    } fa_result_t;
endpackage

// File: rtl/full_adder_fa_bit.sv
// fa_bit: combinational one-bit full adder cell
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder of fa_bit cells; FULL_ADDER_REG_OUT_EN adds a one-cycle output register
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);
    logic [WIDTH:0] c;
    logic [WIDTH-1:0] s;
    fa_result_t res;
    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
        $error("full_adder: WIDTH %0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
    end
    assign c[0] = cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_bit u_bit (
            .a (a[i]),
            .b (b[i]),
            .ci(c[i]),
            .s (s[i]),
            .co(c[i+1])
        );
    end
    always_comb begin
        res = '0;
        res.sum = FA_MAX_WIDTH'(s);
        res.cout = c[WIDTH];
        res.ovf = c[WIDTH-1] ^ c[WIDTH];
    end
`ifdef FULL_ADDER_REG_OUT_EN
    fa_result_t r;
    logic v;
    always_ff @(posedge clk) begin
        r <= rst_n ? res : '0;
        v <= rst_n & in_valid;
    end
    assign sum = r.sum[WIDTH-1:0];
    assign cout = r.cout;
    assign ovf = r.ovf;
    assign out_valid = v;
    // bits above WIDTH are always zero and never observed
    logic unused_hi;
    assign unused_hi = &{1'b0, r.sum};
`else
    assign sum = res.sum[WIDTH-1:0];
    assign cout = res.cout;
    assign ovf = res.ovf;
    assign out_valid = in_valid;
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, res.sum};
`endif
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed tables, random sweep and register/reset sequences for full_adder
module tb_full_adder;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic a1 = 0, b1 = 0, ci1 = 0, iv1 = 0, s1, co1, ov1, v1;
    logic [3:0] a4 = 0, b4 = 0, s4;
    logic ci4 = 0, iv4 = 0, co4, ov4, v4;
    logic [9:0] a10 = 0, b10 = 0, s10;
    logic ci10 = 0, iv10 = 0, co10, ov10, v10;
    logic [7:0] a8 = 0, b8 = 0, s8;
    logic ci8 = 0, iv8 = 0, co8, ov8, v8;

    full_adder #(.WIDTH(1)) d1 (.clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(ci1), .in_valid(iv1),
        .sum(s1), .cout(co1), .ovf(ov1), .out_valid(v1));
    full_adder #(.WIDTH(4)) d4 (.clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(ci4), .in_valid(iv4),
        .sum(s4), .cout(co4), .ovf(ov4), .out_valid(v4));
    full_adder #(.WIDTH(10)) d10 (.clk(clk), .rst_n(rst_n), .a(a10), .b(b10), .cin(ci10), .in_valid(iv10),
        .sum(s10), .cout(co10), .ovf(ov10), .out_valid(v10));
    full_adder #(.WIDTH(8)) d8 (.clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(ci8), .in_valid(iv8),
        .sum(s8), .cout(co8), .ovf(ov8), .out_valid(v8));

    typedef struct {
        logic [3:0] a, b;
        logic       ci;
        logic [3:0] s;
        logic       co, ov;
    } vec_t;

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic settle;
`ifdef FULL_ADDER_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    initial begin
        vec_t t1[8];
        vec_t t4[5];
        logic [10:0] full;
        logic eov;
        // {a, b, cin} -> {sum, cout, ovf}, ovf = cin ^ cout at WIDTH 1
        t1[0] = '{0, 0, 0, 0, 0, 0};
        t1[1] = '{0, 0, 1, 1, 0, 1};
        t1[2] = '{0, 1, 0, 1, 0, 0};
        t1[3] = '{0, 1, 1, 0, 1, 0};
        t1[4] = '{1, 0, 0, 1, 0, 0};
        t1[5] = '{1, 0, 1, 0, 1, 0};
        t1[6] = '{1, 1, 0, 0, 1, 1};
        t1[7] = '{1, 1, 1, 1, 1, 0};
        t4[0] = '{4'hF, 4'h1, 0, 4'h0, 1, 0};
        t4[1] = '{4'h7, 4'h1, 0, 4'h8, 0, 1};
        t4[2] = '{4'h8, 4'h8, 0, 4'h0, 1, 1};
        t4[3] = '{4'h3, 4'h4, 1, 4'h8, 0, 1};
        t4[4] = '{4'hF, 4'hF, 1, 4'hF, 1, 0};

`ifdef FULL_ADDER_REG_OUT_EN
        a8 = 8'hAA; b8 = 8'h77; ci8 = 1; iv8 = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_w8", {s8, co8, ov8, v8}, 16'h0);
        chk("reset_w1", {s1, co1, ov1, v1}, 16'h0);
        rst_n = 1;
        a8 = 8'hFF; b8 = 8'h01; ci8 = 1; iv8 = 1;
        settle();
        chk("first_w8", {s8, co8, ov8, v8}, {8'h01, 1'b1, 1'b0, 1'b1});
        a8 = 8'h10; b8 = 8'h20; ci8 = 0;
        settle();
        chk("stream0", {s8, co8, ov8, v8}, {8'h30, 1'b0, 1'b0, 1'b1});
        a8 = 8'h7F; b8 = 8'h01; ci8 = 0;
        rst_n = 0;
        settle();
        chk("midrst", {s8, co8, ov8, v8}, 16'h0);
        rst_n = 1;
        a8 = 8'h80; b8 = 8'h80; ci8 = 1;
        settle();
        chk("resume", {s8, co8, ov8, v8}, {8'h01, 1'b1, 1'b1, 1'b1});
        iv8 = 0; a8 = 8'h05; b8 = 8'h06; ci8 = 0;
        settle();
        chk("noval", {s8, co8, ov8, v8}, {8'h0B, 1'b0, 1'b0, 1'b0});
`else
        a8 = 8'h80; b8 = 8'h80; ci8 = 0; iv8 = 1;
        settle();
        chk("rst_ignored", {s8, co8, ov8, v8}, {8'h00, 1'b1, 1'b1, 1'b1});
        rst_n = 1;
        a8 = 8'hFF; b8 = 8'h01; ci8 = 1; iv8 = 0;
        settle();
        chk("w8_ff01", {s8, co8, ov8, v8}, {8'h01, 1'b1, 1'b0, 1'b0});
`endif
        iv1 = 1;
        for (int i = 0; i < 8; i++) begin
            a1 = t1[i].a[0]; b1 = t1[i].b[0]; ci1 = t1[i].ci;
            settle();
            chk($sformatf("w1[%0d]", i), {s1, co1, ov1, v1}, {t1[i].s[0], t1[i].co, t1[i].ov, 1'b1});
        end
        iv4 = 1;
        for (int i = 0; i < 5; i++) begin
            a4 = t4[i].a; b4 = t4[i].b; ci4 = t4[i].ci;
            settle();
            chk($sformatf("w4[%0d]", i), {s4, co4, ov4, v4}, {t4[i].s, t4[i].co, t4[i].ov, 1'b1});
        end
        for (int i = 0; i < 10000; i++) begin
            a10 = 10'($urandom); b10 = 10'($urandom);
            ci10 = 1'($urandom); iv10 = 1'($urandom);
            full = 11'(a10) + 11'(b10) + 11'(ci10);
            eov = (a10[9] == b10[9]) && (full[9] != a10[9]);
            settle();
            if ({co10, s10, ov10, v10} !== {full, eov, iv10})
                chk($sformatf("w10[%0d]", i), {1'b0, co10, s10, ov10, v10}, {1'b0, full, eov, iv10});
            else
                n_vec++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/full_adder.md
# full_adder

Parameterisable ripple-carry full adder, the basic arithmetic cell of the multiply datapath. The serial `adder` chains these cells two bits per cycle, with the inter-cycle carry held in an external flop. With the default `WIDTH = 1` it is the classic one-bit full adder. An optional compile-time output register turns it into a one-cycle pipelined stage.

## Interface
Parameters:
- `WIDTH`, default 1: operand width, number of chained one-bit cells; legal range 1..64.

Ports:
- `clk`, in, 1: single clock. Used only when the output register is compiled in.
- `rst_n`, in, 1: reset; synchronous, active-low. Used only when the output register is compiled in.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B.
- `cin`, in, 1: carry into bit 0.
- `in_valid`, in, 1: operands valid qualifier.
- `sum`, out, WIDTH: `(a + b + cin)` mod 2^WIDTH.
- `cout`, out, 1: carry out of the MSB.
- `ovf`, out, 1: two's-complement overflow, defined as the carry into the MSB XOR `cout`. When `WIDTH = 1` it equals `cin ^ cout`.
- `out_valid`, out, 1: result valid qualifier.

## Operation
- Per-bit cell i computes:
  - `s[i] = a[i] ^ b[i] ^ c[i]`
  - `c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i]`
  - with `c[0] = cin`.
- Outputs map as: `sum = s[WIDTH-1:0]`, `cout = c[WIDTH]`, `ovf = c[WIDTH-1] ^ c[WIDTH]`.
- The arithmetic is unsigned modulo 2^WIDTH. `cout` carries bit WIDTH of the full sum, which ranges 0..2^(WIDTH+1)-1.
- There is no internal state other than the optional output register. There is no FSM.
- `in_valid` does not gate the arithmetic; it is only forwarded to `out_valid`.
- All instantiations connect ports by name.

## Timing
Combinational build (macro undefined):
- Zero latency; outputs follow inputs within the same cycle.
- `out_valid = in_valid`.
- `clk` and `rst_n` are ignored, so there is no reset value.

Registered build (macro defined):
- One-cycle latency. `sum`, `cout`, `ovf` and `out_valid` capture the combinational result at each `posedge clk`.
- The register loads every cycle, independent of `in_valid`.
- Reset value: when `rst_n = 0` at a posedge, all outputs are 0 on the following cycle.
- Reset mid-stream discards the in-flight result. The first valid result reappears one cycle after `rst_n` returns high with `in_valid = 1`.
- Back-to-back operands are accepted every cycle. There is no backpressure.

## Configuration
- Macro `FULL_ADDER_REG_OUT_EN`.
  - Defined: registered outputs, with the latency and reset behaviour listed under Timing.
  - Undefined (default): purely combinational, which the serial `adder` requires because it consumes the cell result in the same cycle.

## Structure
- Shared package `full_adder_pkg` holds:
  - `FA_MAX_WIDTH = 64`
  - the default-width constant
  - typedef `fa_result_t`, a struct of `sum`, `cout`, `ovf` used for the output register.
- One sub-module, `fa_bit`: a combinational one-bit cell with ports `a`, `b`, `ci`, `s`, `co`. It is generated WIDTH times and chained through the carry vector.
- An elaboration-time check rejects `WIDTH` outside 1..`FA_MAX_WIDTH`.

## Test plan
- Exhaustive at `WIDTH = 1` (combinational), all 8 combinations of `a`/`b`/`cin`. For example, 1/1/1 gives `sum=1`, `cout=1`; 1/0/0 gives `sum=1`, `cout=0`; 1/1/0 gives `sum=0`, `cout=1`.
- `WIDTH = 4`, `a=4'hF`, `b=4'h1`, `cin=0`: `sum=4'h0`, `cout=1`, `ovf=0`.
- `WIDTH = 4`, `a=4'h7`, `b=4'h1`, `cin=0`: `sum=4'h8`, `cout=0`, `ovf=1`. Then `a=4'h8`, `b=4'h8`: `sum=4'h0`, `cout=1`, `ovf=1`.
- `WIDTH = 10` random sweep of 10 000 vectors: `{cout, sum}` equals `a + b + cin`, and `out_valid` tracks `in_valid` in the same cycle.
- Registered build, `WIDTH = 8`, `rst_n=0` for 2 cycles: all outputs 0. Release, then apply `a=8'hFF`, `b=8'h01`, `cin=1`, `in_valid=1` at cycle N: at cycle N+1, `sum=8'h01`, `cout=1`, `out_valid=1`.
- Registered build: assert `rst_n=0` while a stream is running. The next cycle shows all outputs 0, and results resume one cycle after release.
